// File: rtl/note_pkg.sv
// note_pkg: ASCII constants, note codes, FSM states and character helpers for ascii_to_note.
// Lowercase a..g acceptance is enabled by ASCII_TO_NOTE_LOWERCASE_EN.
package note_pkg;
   localparam logic [7:0] SPACE = 8'h20, POUND = 8'h23;
   localparam logic [7:0] CH_A = 8'h41, CH_B = 8'h42, CH_C = 8'h43, CH_D = 8'h44;
   localparam logic [7:0] CH_E = 8'h45, CH_F = 8'h46, CH_G = 8'h47;
   localparam logic [3:0] NOTE_REST = 4'd0, NOTE_C = 4'd1, NOTE_CS = 4'd2, NOTE_D = 4'd3;
   localparam logic [3:0] NOTE_DS = 4'd4, NOTE_E = 4'd5, NOTE_F = 4'd6, NOTE_FS = 4'd7;
   localparam logic [3:0] NOTE_G = 4'd8, NOTE_GS = 4'd9, NOTE_A = 4'd10, NOTE_AS = 4'd11;
   localparam logic [3:0] NOTE_B = 4'd12;
   typedef enum logic {FIRST, SECOND} state_t;
   function automatic logic [7:0] norm_char(input logic [7:0] c);
`ifdef ASCII_TO_NOTE_LOWERCASE_EN
      return (c >= 8'h61 && c <= 8'h67) ? c - 8'h20 : c;
`else
      return c;
`endif
   endfunction
   function automatic logic is_start(input logic [7:0] c);
      return c == SPACE || (c >= CH_A && c <= CH_G);
   endfunction
endpackage

// File: rtl/ascii_to_note_if.sv
// ascii_to_note_if: character input and note output valid/ready handshakes.
interface ascii_to_note_if;
   logic [7:0] asciiChar;
   logic       charValid;
   logic       charReady;
   logic [3:0] noteHex;
   logic       noteValid;
   logic       noteReady;
   modport master (output asciiChar, charValid, noteReady, input charReady, noteHex, noteValid);
   modport slave (input asciiChar, charValid, noteReady, output charReady, noteHex, noteValid);
endinterface

// File: rtl/note_pair_decode.sv
// note_pair_decode: combinational lookup of a (first, second) character cell to {legal, code}.
module note_pair_decode
   import note_pkg::*;
(
   input  logic [7:0] first_char,
   input  logic [7:0] second_char,
   output logic       legal,
   output logic [3:0] code
);
   logic [3:0] base;
   logic       sharp_ok, known;
   always_comb begin
      base = NOTE_REST;
      sharp_ok = 1'b0;
      known = 1'b1;
      case (first_char)
         SPACE: base = NOTE_REST;
         CH_C: begin base = NOTE_C; sharp_ok = 1'b1; end
         CH_D: begin base = NOTE_D; sharp_ok = 1'b1; end
         CH_E: base = NOTE_E;
         CH_F: begin base = NOTE_F; sharp_ok = 1'b1; end
         CH_G: begin base = NOTE_G; sharp_ok = 1'b1; end
         CH_A: begin base = NOTE_A; sharp_ok = 1'b1; end
         CH_B: base = NOTE_B;
         default: known = 1'b0;
      endcase
      legal = known & (second_char == SPACE | (second_char == POUND & sharp_ok));
      code = base + {3'b0, second_char == POUND};
   end
endmodule

// File: rtl/ascii_to_note.sv
// ascii_to_note: decodes two-character ASCII cells into 4-bit note codes with error counting.
// Define ASCII_TO_NOTE_LOWERCASE_EN to accept lowercase a..g.
module ascii_to_note
   import note_pkg::*;
#(
   parameter int TIMEOUT = 1000,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            reset,
   ascii_to_note_if.slave  bus,
   output logic            errPulse,
   output logic [7:0]      errCount
);
   localparam logic [CNT_W-1:0] TLAST = CNT_W'(TIMEOUT - 1);
   state_t           state, state_n;
   logic [7:0]       first_char, first_n, c;
   logic [CNT_W-1:0] timer, timer_n;
   logic [3:0]       hex_n, code;
   logic             valid_n, err, legal, acc;
   assign c = norm_char(bus.asciiChar);
   assign bus.charReady = state == FIRST | !bus.noteValid | bus.noteReady;
   assign acc = bus.charValid & bus.charReady;
   note_pair_decode u_dec (.first_char(first_char), .second_char(c), .legal(legal), .code(code));
   always_comb begin
      state_n = state;
      first_n = first_char;
      timer_n = timer;
      err = 1'b0;
      hex_n = bus.noteHex;
      valid_n = bus.noteValid & !bus.noteReady;
      if (state == FIRST) begin
         if (acc && is_start(c)) begin
            state_n = SECOND;
            first_n = c;
            timer_n = '0;
         end else if (acc) err = 1'b1;
      end else if (acc && legal) begin
         hex_n = code;
         valid_n = 1'b1;
         state_n = FIRST;
      end else if (acc) begin
         // a bad second character that could start a cell resynchronises onto it
         err = 1'b1;
         first_n = c;
         timer_n = '0;
         state_n = is_start(c) ? SECOND : FIRST;
      end else if (TIMEOUT != 0 && timer == TLAST) begin
         err = 1'b1;
         state_n = FIRST;
      end else timer_n = timer + CNT_W'(1);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FIRST;
         first_char <= SPACE;
         timer <= '0;
         bus.noteHex <= '0;
         bus.noteValid <= 1'b0;
         errPulse <= 1'b0;
         errCount <= '0;
      end else begin
         state <= state_n;
         first_char <= first_n;
         timer <= timer_n;
         bus.noteHex <= hex_n;
         bus.noteValid <= valid_n;
         errPulse <= err;
         errCount <= errCount + {7'b0, err & (errCount != 8'hFF)};
      end
   end
endmodule
